// File: rtl/cpu_ctrl_pkg.sv
// Shared types and defaults for the CPU run/step controller.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    HALT = 2'd0,
    STEP = 2'd1,
    RUN  = 2'd2
  } run_state_t;

  // 10 ms of stable samples at the 23 MHz CPU clock
  localparam int DEBOUNCE_CYCLES_DFLT = 230000;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus stable-sample counter for the step push-button.
// btn_db only changes after DEBOUNCE_CYCLES consecutive samples that differ from it.
module btn_debounce
  import cpu_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DFLT
) (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic btn_db
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

  logic [1:0]    sync;
  logic          btn_s;
  logic [CW-1:0] cnt;

  assign btn_s = sync[1];

  // bring the raw button into the clock domain
  always_ff @(posedge clock) begin
    if (reset) sync <= 2'b00;
    else       sync <= {sync[0], btn};
  end

  // count consecutive disagreeing samples; accept the new level on the last one
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt    <= '0;
      btn_db <= 1'b0;
    end else if (btn_s == btn_db) begin
      cnt <= '0;
    end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      cnt    <= '0;
      btn_db <= btn_s;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step controller: turns run switch, debounced step button and CPU halt
// request into a registered clock-enable for the single-cycle CPU.
// Optional feature macro: CPU_CYCLE_CNT_EN builds the executed-cycle counter;
// without it cycle_cnt is tied to zero.
module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DFLT,
  parameter int CNT_W           = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run_sw,
  input  logic             step_btn,
  input  logic             halt_req,
  output logic             cpu_en,
  output logic             running,
  output logic             halted_by_cpu,
  output logic [CNT_W-1:0] cycle_cnt
);

  run_state_t state;
  logic [1:0] run_sync;
  logic       run_s;
  logic       step_db, step_db_q, step_evt;
  logic       run_ok;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
    .clock  (clock),
    .reset  (reset),
    .btn    (step_btn),
    .btn_db (step_db)
  );

  assign run_s    = run_sync[1];
  assign step_evt = step_db & ~step_db_q;
  // a CPU-requested halt blocks free-run until the switch is cycled
  assign run_ok   = run_s & ~halted_by_cpu;

  // run switch synchroniser and step edge-detect history
  always_ff @(posedge clock) begin
    if (reset) begin
      run_sync  <= 2'b00;
      step_db_q <= 1'b0;
    end else begin
      run_sync  <= {run_sync[0], run_sw};
      step_db_q <= step_db;
    end
  end

  // run/step FSM with registered Moore outputs; RUN beats a coincident step
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= HALT;
      cpu_en        <= 1'b0;
      running       <= 1'b0;
      halted_by_cpu <= 1'b0;
    end else begin
      case (state)
        HALT: begin
          if (run_ok) begin
            state   <= RUN;
            cpu_en  <= 1'b1;
            running <= 1'b1;
          end else if (step_evt) begin
            state  <= STEP;
            cpu_en <= 1'b1;
          end
        end
        STEP: begin
          state  <= HALT;
          cpu_en <= 1'b0;
        end
        RUN: begin
          if (halt_req) begin
            state         <= HALT;
            cpu_en        <= 1'b0;
            running       <= 1'b0;
            halted_by_cpu <= 1'b1;
          end else if (!run_s) begin
            state   <= HALT;
            cpu_en  <= 1'b0;
            running <= 1'b0;
          end
        end
        default: begin
          state   <= HALT;
          cpu_en  <= 1'b0;
          running <= 1'b0;
        end
      endcase
      // switch low re-arms free-run; overrides a same-edge halt
      if (!run_s) halted_by_cpu <= 1'b0;
    end
  end

`ifdef CPU_CYCLE_CNT_EN
  // count enabled CPU cycles, wrapping freely
  always_ff @(posedge clock) begin
    if (reset)       cycle_cnt <= '0;
    else if (cpu_en) cycle_cnt <= cycle_cnt + CNT_W'(1);
  end
`else
  assign cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Randomised and directed bench for cpu_run_ctrl against a behavioural model.
module tb_cpu_run_ctrl;

  localparam int DB = 4;
  localparam int CW = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          run_sw = 1'b0, step_btn = 1'b0, halt_req = 1'b0;
  logic          cpu_en, running, halted_by_cpu;
  logic [CW-1:0] cycle_cnt;

  int n_chk = 0, n_bad = 0;

  cpu_run_ctrl #(.DEBOUNCE_CYCLES(DB), .CNT_W(CW)) dut (
    .clock         (clock),
    .reset         (reset),
    .run_sw        (run_sw),
    .step_btn      (step_btn),
    .halt_req      (halt_req),
    .cpu_en        (cpu_en),
    .running       (running),
    .halted_by_cpu (halted_by_cpu),
    .cycle_cnt     (cycle_cnt)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Inputs reach the controller through a 2-sample delay line; the button
  // level is accepted once the last DB delayed samples all disagree with it.
  bit rq[$], sq[$], sh[$];
  bit m_run_s, m_step_s, m_db, m_db_prev;
  bit m_run, m_en, m_hbc;
  int m_cnt;

  task automatic model_edge(input bit rst, input bit rs, input bit sb, input bit hr);
    bit evt, n_run, n_en, n_hbc, n_db, all_diff;
    if (rst) begin
      rq.delete(); sq.delete(); sh.delete();
      m_run_s = 0; m_step_s = 0; m_db = 0; m_db_prev = 0;
      m_run = 0; m_en = 0; m_hbc = 0; m_cnt = 0;
      return;
    end
    evt   = m_db && !m_db_prev;
    n_hbc = m_hbc;
    if (m_run) begin
      n_run = 1;
      if (hr) begin n_run = 0; n_hbc = 1; end
      else if (!m_run_s) n_run = 0;
      n_en = n_run;
    end else if (m_en) begin
      n_run = 0; n_en = 0;              // single step just happened
    end else if (m_run_s && !m_hbc) begin
      n_run = 1; n_en = 1;
    end else begin
      n_run = 0; n_en = evt;
    end
    if (!m_run_s) n_hbc = 0;
    if (m_en) m_cnt++;
    // debounce on history of delayed samples
    sh.push_back(m_step_s);
    if (sh.size() > DB) void'(sh.pop_front());
    n_db = m_db;
    if (sh.size() == DB) begin
      all_diff = 1;
      foreach (sh[i]) if (sh[i] == m_db) all_diff = 0;
      if (all_diff) n_db = !m_db;
    end
    m_db_prev = m_db; m_db = n_db;
    rq.push_back(rs); if (rq.size() > 2) void'(rq.pop_front());
    sq.push_back(sb); if (sq.size() > 2) void'(sq.pop_front());
    m_run_s  = (rq.size() == 2) ? rq[0] : 1'b0;
    m_step_s = (sq.size() == 2) ? sq[0] : 1'b0;
    m_run = n_run; m_en = n_en; m_hbc = n_hbc;
  endtask

  function automatic logic [31:0] exp_cnt();
`ifdef CPU_CYCLE_CNT_EN
    return 32'(m_cnt % (1 << CW));
`else
    return 32'd0;
`endif
  endfunction

  // one clock: drive away from the edge, advance model, compare after edge
  task automatic tick(input bit rst, input bit rs, input bit sb, input bit hr);
    @(negedge clock);
    reset = rst; run_sw = rs; step_btn = sb; halt_req = hr;
    @(posedge clock);
    model_edge(rst, rs, sb, hr);
    #1;
    chk("cpu_en",  32'(cpu_en),        32'(m_en));
    chk("running", 32'(running),       32'(m_run));
    chk("halted",  32'(halted_by_cpu), 32'(m_hbc));
    chk("cnt",     32'(cycle_cnt),     exp_cnt());
  endtask

  initial begin
    int guard, en_seen, c0;
    bit rs, sb, hr, rst;

    // reset held with switch up
    for (int i = 0; i < 3; i++) tick(1, 1, 0, 0);
    chk("rst_en", 32'(cpu_en), 0);
    chk("rst_running", 32'(running), 0);
    chk("rst_cnt", 32'(cycle_cnt), 0);
    tick(0, 1, 0, 0); chk("rel_e1", 32'(cpu_en), 0);
    tick(0, 1, 0, 0); chk("rel_e2", 32'(cpu_en), 0);
    tick(0, 1, 0, 0); chk("rel_e3", 32'(cpu_en), 1);

    // free-run 300 enabled cycles
    guard = 0;
    while (m_cnt < 300 && guard < 1000) begin tick(0, 1, 0, 0); guard++; end
    chk("run300_bound", 32'(guard < 1000), 1);
`ifdef CPU_CYCLE_CNT_EN
    chk("cnt_wrap44", 32'(cycle_cnt), 44);
`endif
    tick(0, 0, 0, 0); chk("fall_e1", 32'(cpu_en), 1);
    tick(0, 0, 0, 0); chk("fall_e2", 32'(cpu_en), 1);
    tick(0, 0, 0, 0); chk("fall_e3", 32'(cpu_en), 0);

    // CPU halt and re-arm
    for (int i = 0; i < 4; i++) tick(0, 1, 0, 0);
    chk("rerun", 32'(running), 1);
    tick(0, 1, 0, 1);
    chk("halt_en", 32'(cpu_en), 0);
    chk("halt_flag", 32'(halted_by_cpu), 1);
    for (int i = 0; i < 6; i++) tick(0, 1, 0, 0);
    chk("halt_hold", 32'(cpu_en), 0);
    for (int i = 0; i < 4; i++) tick(0, 0, 0, 0);
    chk("flag_clr", 32'(halted_by_cpu), 0);
    for (int i = 0; i < 3; i++) tick(0, 1, 0, 0);
    chk("resume", 32'(running), 1);
    chk("resume_flag", 32'(halted_by_cpu), 0);
    for (int i = 0; i < 6; i++) tick(0, 0, 0, 0);

    // bouncing press then hold: one step
    c0 = m_cnt; en_seen = 0;
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 3; i++) begin tick(0, 0, 1, 0); en_seen += cpu_en; end
      for (int i = 0; i < 3; i++) begin tick(0, 0, 0, 0); en_seen += cpu_en; end
    end
    for (int i = 0; i < 20; i++) begin tick(0, 0, 1, 0); en_seen += cpu_en; end
    for (int i = 0; i < 12; i++) begin tick(0, 0, 0, 0); en_seen += cpu_en; end
    chk("step_once", 32'(en_seen), 1);
`ifdef CPU_CYCLE_CNT_EN
    chk("step_cnt", 32'(cycle_cnt), 32'((c0 + 1) % (1 << CW)));
`endif

    // short press: no step
    en_seen = 0;
    for (int i = 0; i < 3; i++) begin tick(0, 0, 1, 0); en_seen += cpu_en; end
    for (int i = 0; i < 12; i++) begin tick(0, 0, 0, 0); en_seen += cpu_en; end
    chk("short_press", 32'(en_seen), 0);

    // step edge coincides with run_s rising: RUN wins
    for (int i = 0; i < 4; i++) tick(0, 0, 1, 0);
    tick(0, 1, 1, 0);
    tick(0, 1, 1, 0); chk("coinc_pre", 32'(cpu_en), 0);
    tick(0, 1, 1, 0); chk("coinc_run", 32'(running), 1);
    // presses during RUN are ignored
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 8; i++) tick(0, 1, 1, 0);
      for (int i = 0; i < 8; i++) tick(0, 1, 0, 0);
    end
    chk("run_press", 32'(running), 1);
    for (int i = 0; i < 12; i++) tick(0, 0, 0, 0);

    // randomised traffic
    rs = 0; sb = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 63) == 0) rs = !rs;
      if ($urandom_range(0, 5) == 0)  sb = !sb;
      hr  = ($urandom_range(0, 19) == 0);
      rst = ($urandom_range(0, 499) == 0);
      tick(rst, rs, sb, hr);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run/step controller clocked by the CPU clock produced by the clock-wizard output (`clk_out1` of `cpuclk`). Converts the board's run switch, the raw step push-button and the CPU's halt request into one registered clock-enable, `cpu_en`, which gates every state-holding element of the single-cycle CPU. Sits between the clock generator and the CPU core. Supports free-run, halt-on-instruction and single-cycle stepping for board debugging.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 230000: consecutive stable samples needed before the step button changes level (10 ms at 23 MHz).
- `CNT_W`, 32: width of the executed-cycle counter.

Ports:
- `clock` in 1: CPU clock. One clock domain; all logic is on the rising edge.
- `reset` in 1: reset is synchronous and active-high.
- `run_sw` in 1: asynchronous level input from the board switch; 1 requests free-run.
- `step_btn` in 1: asynchronous, bouncing push-button input.
- `halt_req` in 1: synchronous pulse or level from the CPU; 1 requests a stop.
- `cpu_en` out 1: registered CPU clock-enable.
- `running` out 1: registered; 1 while the FSM is in RUN.
- `halted_by_cpu` out 1: registered sticky flag that records a halt caused by `halt_req`.
- `cycle_cnt` out CNT_W: number of cycles in which `cpu_en` was 1.

## Operation
- Synchronisers: `run_sw` and `step_btn` each pass through a 2-flop synchroniser. The synchronised values are `run_s` and `step_s`.
- Debounce: a counter clears whenever `step_s` equals `step_db`. While the two differ, the counter increments. When it reaches DEBOUNCE_CYCLES-1 while they still differ, `step_db` takes the value of `step_s` and the counter clears. `step_evt` is `step_db` rising (a 0→1 edge), one cycle wide.
- FSM states (Moore outputs):
  - HALT: `cpu_en`=0.
  - STEP: `cpu_en`=1 for exactly one cycle.
  - RUN: `cpu_en`=1 and `running`=1.
- FSM transitions:
  - HALT → RUN when `run_s`=1 and `halted_by_cpu`=0.
  - HALT → STEP when `step_evt`=1 and the RUN condition is false.
  - If the RUN condition and `step_evt` occur in the same cycle, RUN wins and `step_evt` is discarded.
  - STEP → HALT unconditionally.
  - RUN → HALT when `halt_req`=1; `halted_by_cpu` is set to 1 in the same edge.
  - RUN → HALT when `run_s`=0.
  - `step_evt` is ignored while in RUN and while in STEP.
- `halted_by_cpu`: cleared when `run_s`=0. Resuming after a CPU halt therefore needs the switch taken low and then high again. Stepping is still allowed while `halted_by_cpu`=1.
- `cycle_cnt`: increments by 1 on each edge where `cpu_en`=1 and wraps modulo 2^CNT_W with no saturation.
- Reset values: state HALT, `cpu_en`=0, `running`=0, `halted_by_cpu`=0, `cycle_cnt`=0. Synchronisers, `step_db` and the debounce counter all reset to 0. Reset asserted mid-RUN or mid-STEP forces `cpu_en`=0 at the next edge.

## Timing
- `run_sw` rising with the RUN condition true: `cpu_en`=1 at the 3rd rising edge after the change (2 synchroniser edges plus 1 state edge).
- `run_sw` falling: `cpu_en`=0 at the 3rd rising edge after the change.
- `halt_req` sampled 1 at edge N in RUN: `cpu_en`=0 from edge N+1. The instruction that raised `halt_req` completes in cycle N.
- Step: `cpu_en`=1 for exactly one cycle. It starts one edge after `step_evt`, which is DEBOUNCE_CYCLES+2 edges after a clean press.
- A button held down gives exactly one step. A release and a new press are needed for the next step.

## Configuration
- `CPU_CYCLE_CNT_EN` defined: the `cycle_cnt` counter is built as described above.
- `CPU_CYCLE_CNT_EN` undefined: no counter register is built and `cycle_cnt` is tied to 0. The port list is unchanged.

## Structure
- Package `cpu_ctrl_pkg` holds:
  - the `run_state_t` enum (HALT, STEP, RUN);
  - the default `DEBOUNCE_CYCLES` constant, 230000.
- Sub-module `btn_debounce`: synchroniser plus debounce counter, with output `step_db`. The rising-edge detect and the FSM stay in `cpu_run_ctrl`.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, CNT_W=8 and `CPU_CYCLE_CNT_EN` defined.
- Reset: hold `reset`=1 with `run_sw`=1 → `cpu_en`=0, `running`=0, `cycle_cnt`=0. After release, `cpu_en`=1 at the 3rd edge.
- Free-run for 300 enabled cycles, then `run_sw`=0 → `cycle_cnt`=44 (300 mod 256). `cpu_en`=0 at the 3rd edge after the switch falls.
- In RUN, pulse `halt_req` for 1 cycle at edge N → `cpu_en`=0 from N+1 and `halted_by_cpu`=1. Holding `run_sw`=1 keeps the FSM in HALT. Switch 0 then 1 → RUN resumes and the flag is 0.
- In HALT, press `step_btn` with 3-cycle bounces and then hold 20 cycles → exactly one `cpu_en`=1 cycle and `cycle_cnt` increments by 1.
- Clean press held for only 3 cycles → no step.
- Step edge in the same cycle that `run_s` rises → FSM goes to RUN with no extra STEP cycle. Step presses during RUN leave `cpu_en` and `cycle_cnt` unaffected beyond normal run counting.
